// File: rtl/filter_test_sequencer.sv
// Delay-sweep stimulus sequencer for the exp_sig_gen -> v2_filter test chain.
// Each step settles quietly, then measures the signed peak of the filter output and reports it.
module filter_test_sequencer #(
    parameter int SIZE_DELAY       = 8,
    parameter int SIZE_FILTER_DATA = 16,
    parameter int NUM_STEPS        = 4,
    parameter int SETTLE_CYCLES    = 64,
    parameter int MEASURE_CYCLES   = 1024,
    parameter int SIZE_POS         = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               cfg_overlay,
    input  logic [SIZE_DELAY-1:0]              cfg_delay_start,
    input  logic [SIZE_DELAY-1:0]              cfg_delay_step,
    input  logic signed [SIZE_FILTER_DATA+2:0] filter_data,
    output logic                               test_overlay,
    output logic                               test_rate,
    output logic [SIZE_DELAY-1:0]              test_delay,
    output logic                               busy,
    output logic                               done,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [7:0]                         result_step,
    output logic signed [SIZE_FILTER_DATA+2:0] result_peak,
    output logic [SIZE_POS-1:0]                result_pos,
    output logic [2:0]                         state_dbg
);

    localparam int FD_W    = SIZE_FILTER_DATA + 3;
    localparam int CNT_MAX = (SETTLE_CYCLES > MEASURE_CYCLES) ? SETTLE_CYCLES : MEASURE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEASURE_LAST = CNT_W'(MEASURE_CYCLES - 1);
    localparam logic [7:0]       STEP_LAST    = 8'(NUM_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_REPORT  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        cnt;
    logic [7:0]              step;
    logic [SIZE_DELAY-1:0]   delay;
    logic [SIZE_DELAY-1:0]   delay_inc;
    logic                    overlay_lat;
    logic signed [FD_W-1:0]  peak;
    logic [SIZE_POS-1:0]     pos;
    logic                    handshake;

    // Result handshake: result_valid is high for the whole REPORT state and result_*
    // hold steady; a result transfers on the clk edge where result_valid && result_ready.
    // abort on that same edge wins and the result is discarded.
    assign handshake = result_valid && result_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort && state != S_IDLE) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start && !abort)     next_state = S_SETTLE;
                S_SETTLE:  if (cnt == SETTLE_LAST)  next_state = S_MEASURE;
                S_MEASURE: if (cnt == MEASURE_LAST) next_state = S_REPORT;
                S_REPORT:  if (handshake)           next_state = (step == STEP_LAST) ? S_DONE : S_SETTLE;
                S_DONE:                             next_state = S_IDLE;
                default:                            next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        test_rate    = (state == S_MEASURE);
        test_overlay = (state == S_MEASURE) && overlay_lat;
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        result_valid = (state == S_REPORT);
    end

    // Window counter wraps to zero at the end of each phase, so every phase starts from 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            step        <= '0;
            delay       <= '0;
            delay_inc   <= '0;
            overlay_lat <= 1'b0;
            peak        <= '0;
            pos         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        cnt         <= '0;
                        step        <= '0;
                        delay       <= cfg_delay_start;
                        delay_inc   <= cfg_delay_step;
                        overlay_lat <= cfg_overlay;
                    end
                end
                S_SETTLE: begin
                    cnt <= (cnt == SETTLE_LAST) ? '0 : cnt + 1'b1;
                end
                S_MEASURE: begin
                    cnt <= (cnt == MEASURE_LAST) ? '0 : cnt + 1'b1;
                    // Strictly-greater update keeps the first occurrence of the maximum.
                    if (cnt == '0 || filter_data > peak) begin
                        peak <= filter_data;
                        pos  <= SIZE_POS'(cnt);
                    end
                end
                S_REPORT: begin
                    if (handshake && !abort && step != STEP_LAST) begin
                        step  <= step + 8'd1;
                        delay <= delay + delay_inc;
                    end
                end
                default: ;
            endcase
            if (abort) begin
                cnt <= '0;
            end
        end
    end

    assign test_delay  = delay;
    assign result_step = step;
    assign result_peak = peak;
    assign result_pos  = pos;
    assign state_dbg   = state;

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Self-checking bench for filter_test_sequencer: cycle-exact phase model plus a
// scoreboard of per-step peak/position results computed from the recorded stimulus.
module tb_filter_test_sequencer;

    localparam int SIZE_DELAY       = 8;
    localparam int SIZE_FILTER_DATA = 16;
    localparam int FD_W             = SIZE_FILTER_DATA + 3;
    localparam int NUM_STEPS        = 4;
    localparam int SETTLE_CYCLES    = 64;
    localparam int MEASURE_CYCLES   = 1024;
    localparam int SIZE_POS         = 10;
    localparam int RES_W            = 8 + FD_W + SIZE_POS;

    typedef enum int {M_RAMP, M_PEAK, M_NEG, M_RAND} mode_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic                   cfg_overlay = 1'b0;
    logic [SIZE_DELAY-1:0]  cfg_delay_start = '0;
    logic [SIZE_DELAY-1:0]  cfg_delay_step = '0;
    logic signed [FD_W-1:0] filter_data = '0;
    logic                   result_ready = 1'b1;
    logic                   test_overlay;
    logic                   test_rate;
    logic [SIZE_DELAY-1:0]  test_delay;
    logic                   busy;
    logic                   done;
    logic                   result_valid;
    logic [7:0]             result_step;
    logic signed [FD_W-1:0] result_peak;
    logic [SIZE_POS-1:0]    result_pos;
    logic [2:0]             state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int edge_n   = 0;
    int cur_ws   = 0;
    mode_t cur_mode = M_RAMP;
    mode_t step_mode [NUM_STEPS];
    logic signed [FD_W-1:0] hist [int];
    logic [RES_W-1:0] exp_q [$];

    filter_test_sequencer #(
        .SIZE_DELAY(SIZE_DELAY), .SIZE_FILTER_DATA(SIZE_FILTER_DATA), .NUM_STEPS(NUM_STEPS),
        .SETTLE_CYCLES(SETTLE_CYCLES), .MEASURE_CYCLES(MEASURE_CYCLES), .SIZE_POS(SIZE_POS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_overlay(cfg_overlay),
        .cfg_delay_start(cfg_delay_start), .cfg_delay_step(cfg_delay_step),
        .filter_data(filter_data), .test_overlay(test_overlay), .test_rate(test_rate),
        .test_delay(test_delay), .busy(busy), .done(done), .result_valid(result_valid),
        .result_ready(result_ready), .result_step(result_step), .result_peak(result_peak),
        .result_pos(result_pos), .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) if (done) n_done++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic signed [FD_W-1:0] gen_sample(input int e);
        int w;
        w = e - cur_ws;
        case (cur_mode)
            M_RAMP:  return FD_W'(e % 4096);
            M_PEAK:  return (w == 100 || w == 700) ? FD_W'(300) : FD_W'(-5);
            M_NEG:   return FD_W'(-7);
            default: return FD_W'($urandom);
        endcase
    endfunction

    // Inputs set before tick() take effect at the next edge; outputs are observed at the negedge after it.
    task automatic tick();
        logic signed [FD_W-1:0] v;
        v = gen_sample(edge_n + 1);
        filter_data = v;
        hist[edge_n + 1] = v;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    // Reference: the maximum over the window, then the first index holding it.
    function automatic logic [RES_W-1:0] model_result(input int k, input int ws);
        logic signed [FD_W-1:0] mx;
        int ps;
        mx = hist[ws];
        for (int w = 1; w < MEASURE_CYCLES; w++) if (hist[ws + w] > mx) mx = hist[ws + w];
        ps = -1;
        for (int w = 0; w < MEASURE_CYCLES; w++) if (ps < 0 && hist[ws + w] == mx) ps = w;
        return {8'(k), mx, SIZE_POS'(ps)};
    endfunction

    task automatic check_result(input string tag, input logic [RES_W-1:0] e);
        check({tag, "_step"}, result_step, e[RES_W-1 -: 8]);
        check({tag, "_peak"}, $unsigned(result_peak), e[FD_W+SIZE_POS-1 -: FD_W]);
        check({tag, "_pos"}, result_pos, e[SIZE_POS-1:0]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ovl"}, test_overlay, 0);
        check({tag, "_rate"}, test_rate, 0);
        check({tag, "_delay"}, test_delay, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, result_valid, 0);
        check({tag, "_step"}, result_step, 0);
        check({tag, "_peak"}, $unsigned(result_peak), 0);
        check({tag, "_pos"}, result_pos, 0);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rate", test_rate, 0);
        check("abort_ovl", test_overlay, 0);
        check("abort_valid", result_valid, 0);
        check("abort_done", done, 0);
        repeat (3) begin
            tick();
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
        end
        exp_q.delete();
    endtask

    // Driver: one sweep. Negative step indices disable backpressure / abort / reset.
    // abort_w == MEASURE_CYCLES aborts in REPORT together with result_ready=1.
    task automatic do_run(input logic [7:0] dstart, input logic [7:0] dstep, input logic ovl,
                          input int bp_step, input int bp_len, input int abort_step,
                          input int abort_w, input int reset_step, input bit start_while_busy);
        logic [7:0] exp_delay;
        logic [RES_W-1:0] e;
        logic [FD_W-1:0] kpeak;
        int ws;
        hist.delete();
        cfg_delay_start = dstart;
        cfg_delay_step  = dstep;
        cfg_overlay     = ovl;
        result_ready    = 1'b1;
        cur_mode        = step_mode[0];
        cur_ws          = edge_n + 1 + SETTLE_CYCLES + 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_delay_start = 8'($urandom);
        cfg_delay_step  = 8'($urandom);
        cfg_overlay     = 1'($urandom);
        exp_delay = dstart;
        ws = edge_n + SETTLE_CYCLES + 1;
        for (int k = 0; k < NUM_STEPS; k++) begin
            cur_mode = step_mode[k];
            cur_ws   = ws;
            if (k == bp_step) result_ready = 1'b0;
            while (edge_n < ws - 1) begin
                check("settle_rate", test_rate, 0);
                check("settle_ovl", test_overlay, 0);
                check("settle_busy", busy, 1);
                check("settle_valid", result_valid, 0);
                check("settle_delay", test_delay, exp_delay);
                start = start_while_busy && k == 1 && (edge_n == ws - SETTLE_CYCLES - 1);
                tick();
            end
            start = 1'b0;
            for (int w = 0; w < MEASURE_CYCLES; w++) begin
                check("meas_rate", test_rate, 1);
                check("meas_ovl", test_overlay, ovl);
                check("meas_valid", result_valid, 0);
                if (w == 0) check("meas_delay", test_delay, exp_delay);
                if (k == abort_step && w == abort_w) begin
                    do_abort();
                    return;
                end
                tick();
            end
            exp_q.push_back(model_result(k, ws));
            check("report_valid", result_valid, 1);
            check("report_rate", test_rate, 0);
            check("report_done", done, 0);
            if (step_mode[k] == M_PEAK) begin
                kpeak = FD_W'(300);
                check("peak_300", $unsigned(result_peak), kpeak);
                check("peak_pos_100", result_pos, 100);
            end else if (step_mode[k] == M_NEG) begin
                kpeak = FD_W'(-7);
                check("neg_peak", $unsigned(result_peak), kpeak);
                check("neg_pos_0", result_pos, 0);
            end
            if (k == abort_step && abort_w == MEASURE_CYCLES) begin
                result_ready = 1'b1;
                do_abort();
                return;
            end
            if (k == reset_step) begin
                #2;
                reset = 1'b0;
                #1;
                check_all_zero("async_rst");
                @(posedge clk);
                edge_n++;
                @(negedge clk);
                check("rst_hold_busy", busy, 0);
                reset = 1'b1;
                tick();
                check("rst_after_busy", busy, 0);
                check("rst_after_valid", result_valid, 0);
                exp_q.delete();
                return;
            end
            if (k == bp_step) begin
                for (int i = 0; i < bp_len; i++) begin
                    check("bp_valid", result_valid, 1);
                    check("bp_rate", test_rate, 0);
                    check_result("bp_hold", exp_q[0]);
                    tick();
                end
                result_ready = 1'b1;
            end
            e = exp_q.pop_front();
            check_result("sb", e);
            tick();
            check("post_hs_valid", result_valid, 0);
            check("post_hs_rate", test_rate, 0);
            if (k == NUM_STEPS - 1) begin
                check("done_pulse", done, 1);
                check("done_busy", busy, 1);
                tick();
                check("done_clear", done, 0);
                check("busy_fall", busy, 0);
            end else begin
                check("settle_next_busy", busy, 1);
                check("no_early_done", done, 0);
                exp_delay = exp_delay + dstep;
                ws = edge_n + SETTLE_CYCLES + 1;
            end
        end
    endtask

    initial begin
        int d0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Basic sweep with ramp stimulus
        step_mode = '{M_RAMP, M_RAMP, M_RAMP, M_RAMP};
        d0 = n_done;
        do_run(8'd10, 8'd5, 1'($urandom), -1, 0, -1, 0, -1, 1'b0);
        check("basic_done_count", n_done - d0, 1);

        // Peak tracking, all-negative window, random data
        step_mode = '{M_PEAK, M_NEG, M_RAND, M_RAMP};
        do_run(8'($urandom), 8'($urandom), 1'b1, -1, 0, -1, 0, -1, 1'b0);

        // Backpressure on step 1 plus a start pulse while busy
        step_mode = '{M_RAND, M_RAND, M_RAND, M_RAND};
        d0 = n_done;
        do_run(8'($urandom), 8'($urandom), 1'b0, 1, 50, -1, 0, -1, 1'b1);
        check("bp_done_count", n_done - d0, 1);

        // Delay wrap: 250, 254, 2, 6
        do_run(8'd250, 8'd4, 1'b1, -1, 0, -1, 0, -1, 1'b0);

        // Abort in MEASURE at w=500, then a fresh full sweep
        d0 = n_done;
        do_run(8'($urandom), 8'($urandom), 1'b1, -1, 0, 1, 500, -1, 1'b0);
        check("abort_done_count", n_done - d0, 0);
        do_run(8'($urandom), 8'($urandom), 1'($urandom), -1, 0, -1, 0, -1, 1'b0);

        // Abort together with the final handshake: no done
        d0 = n_done;
        do_run(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b0, -1, 0,
               NUM_STEPS - 1, MEASURE_CYCLES, -1, 1'b0);
        check("abort_hs_done_count", n_done - d0, 0);

        // Async reset during REPORT of step 2
        step_mode = '{M_RAND, M_RAND, M_PEAK, M_RAND};
        do_run(8'($urandom), 8'($urandom), 1'b1, -1, 0, -1, 0, 2, 1'b0);

        // start and abort together in IDLE
        d0 = n_done;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        repeat (SETTLE_CYCLES + 2) tick();
        check("start_abort_rate", test_rate, 0);
        check("start_abort_busy2", busy, 0);
        check("start_abort_done", n_done - d0, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
